debouncer_multi: RTL
====================

// Module: debouncer_multi
// PURPOSE
//  NumCh-channel switch/button debouncer, parametrised successor of the single-channel debouncer.
//  Per channel: input synchroniser, stable-time filter, debounced level, rise/fall ticks and
//  long-press detection. A sticky per-channel event register drives one aggregate interrupt.
//  Sits between board pins (buttons/switches) and control logic or a CSR block.
// PARAMETERS
//  ClkFreq      100_000_000  clock frequency in Hz; must be a multiple of 1000
//  StableTimeMs 10           ms input must differ from level before level flips
//  LongPressMs  1000         ms level must stay high before long_o pulses (>=1)
//  NumCh        4            number of independent channels (>=1)
//  SyncStages   2            synchroniser flops per channel (>=2)
// PORTS
//  clk_i      in   1      clock
//  rst_i      in   1      asynchronous reset, active-low (asserted when 0)
//  sw_i       in   NumCh  raw asynchronous switch inputs
//  db_level_o out  NumCh  debounced level
//  rise_o     out  NumCh  1-cycle pulse, db_level 0->1
//  fall_o     out  NumCh  1-cycle pulse, db_level 1->0
//  long_o     out  NumCh  1-cycle pulse, level high for LongPressMs
//  pend_o     out  NumCh  sticky event flags (any of rise/fall/long)
//  clr_i      in   NumCh  clear pend_o bit (level, sampled each cycle)
//  irq_o      out  1      OR of pend_o, registered
// BEHAVIOUR
//  - Derived: CycPerMs = ClkFreq/1000; StableCycles = CycPerMs*StableTimeMs (elab check >=2).
//  - Reset (rst_i=0, async): all sync flops, counters, db_level_o, rise/fall/long_o, pend_o and
//    irq_o = 0. Reset mid-count discards state. After release the channel re-qualifies from 0.
//  - Sync: sw_i[c] passes through SyncStages flops -> s[c]. No other logic touches raw sw_i.
//  - Filter per channel, counter cnt width $clog2(StableCycles):
//    s==db_level -> cnt<=0 (glitch restart). s!=db_level and cnt<StableCycles-1 -> cnt++.
//    s!=db_level and cnt==StableCycles-1 -> db_level<=s, cnt<=0.
//    The level flips after exactly StableCycles consecutive differing samples.
//  - Latency: a clean sw_i edge makes db_level_o change SyncStages+StableCycles clocks later (+-1
//    for async sampling). Any bounce restarts the count.
//  - rise_o/fall_o are registered. They assert in the same cycle db_level_o shows the new value,
//    for 1 cycle, and are mutually exclusive per channel.
//  - ms prescaler: one shared counter 0..CycPerMs-1, ms_tick=1 on wrap. Free-running from reset.
//  - Long press per channel, counter lp (saturating, width $clog2(LongPressMs+1)):
//    db_level=0 -> lp<=0. db_level=1 and ms_tick and lp<LongPressMs -> lp++.
//    long_o pulses 1 cycle on the transition lp: LongPressMs-1 -> LongPressMs, then never again
//    until the level falls. Resolution +-1 ms (prescaler phase). Press shorter than
//    LongPressMs-1 ms gives no long_o.
//  - pend_o[c] next = (pend_o[c] & ~clr_i[c]) | rise|fall|long. Set wins over a simultaneous clear.
//  - irq_o <= |pend_o, so it lags pend_o by 1 cycle.
//  - Channels are fully independent; simultaneous events on several channels all register.
// TESTING (bench params: ClkFreq=10_000, StableTimeMs=1, LongPressMs=3, NumCh=4, SyncStages=2
//   -> StableCycles=10, CycPerMs=10)
//  T1 reset: rst_i=0 with sw_i=4'hF -> all outputs 0. Release: db_level_o=4'hF after 12+-1 clk,
//     rise_o=4'hF for exactly 1 clk.
//  T2 bounce: ch0 toggles every 5 clk for 60 clk, then holds 1 -> no rise_o until 12+-1 clk
//     after the last edge, then one rise_o pulse and pend_o[0]=1, irq_o=1 one clk later.
//  T3 long press: ch1 held 1 for 40 clk after qualifying -> exactly one long_o[1] 20-30 clk after
//     rise_o[1]. Release -> fall_o[1] 12+-1 clk later. Second press <20 clk -> no long_o.
//  T4 clear race: clr_i[2]=1 in the same cycle as rise_o[2] -> pend_o[2] stays 1. clr_i next
//     cycle -> 0, irq_o drops 1 clk later if no other pend.
//  T5 reset mid-op: ch3 at cnt=7 with level 1 -> rst_i low 3 clk -> db_level 0, no pulses during
//     reset. After release, re-qualifies in 12+-1 clk.
//  T6 parallel: all 4 channels rise in the same cycle -> 4 simultaneous rise_o, pend_o=4'hF.
//     Independent clears work per bit.

Source files
------------

// File: rtl/debouncer_multi.sv
// ----------------------------------------------------------------------------
// debouncer_multi
//
// Multi-channel switch/button debouncer. Each channel has its own input
// synchroniser, a stable-time filter that produces the debounced level,
// registered rise/fall ticks and a long-press detector. A sticky per-channel
// event register collects every tick and feeds one registered interrupt.
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous reset, active-low
//   sw_i        raw asynchronous switch inputs, one bit per channel
//   db_level_o  debounced level per channel
//   rise_o      1-cycle pulse when db_level goes 0->1
//   fall_o      1-cycle pulse when db_level goes 1->0
//   long_o      1-cycle pulse once the level has been high for LongPressMs
//   pend_o      sticky event flags (any of rise/fall/long)
//   clr_i       per-channel clear of pend_o (level, sampled every cycle)
//   irq_o       registered OR of pend_o
// ----------------------------------------------------------------------------
module debouncer_multi #(
    parameter int ClkFreq      = 100_000_000,
    parameter int StableTimeMs = 10,
    parameter int LongPressMs  = 1000,
    parameter int NumCh        = 4,
    parameter int SyncStages   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] sw_i,
    output logic [NumCh-1:0] db_level_o,
    output logic [NumCh-1:0] rise_o,
    output logic [NumCh-1:0] fall_o,
    output logic [NumCh-1:0] long_o,
    output logic [NumCh-1:0] pend_o,
    input  logic [NumCh-1:0] clr_i,
    output logic             irq_o
);

    localparam int CycPerMs     = ClkFreq / 1000;
    localparam int StableCycles = CycPerMs * StableTimeMs;
    localparam int CntW         = (StableCycles > 1) ? $clog2(StableCycles) : 1;
    localparam int LpW          = (LongPressMs > 0) ? $clog2(LongPressMs + 1) : 1;
    localparam int PsW          = (CycPerMs > 1) ? $clog2(CycPerMs) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);
    localparam logic [LpW-1:0]  LpMax  = LpW'(LongPressMs);
    localparam logic [LpW-1:0]  LpPre  = LpW'(LongPressMs - 1);
    localparam logic [PsW-1:0]  PsMax  = PsW'(CycPerMs - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (ClkFreq % 1000 != 0) begin : g_chk_freq
        $error("debouncer_multi: ClkFreq must be a multiple of 1000");
    end
    if (StableCycles < 2) begin : g_chk_stable
        $error("debouncer_multi: StableCycles must be at least 2");
    end
    if (LongPressMs < 1) begin : g_chk_long
        $error("debouncer_multi: LongPressMs must be at least 1");
    end
    if (NumCh < 1) begin : g_chk_numch
        $error("debouncer_multi: NumCh must be at least 1");
    end
    if (SyncStages < 2) begin : g_chk_sync
        $error("debouncer_multi: SyncStages must be at least 2");
    end

    // ------------------------------------------------------------------------
    // Input synchroniser: the only logic that touches the raw pins
    // ------------------------------------------------------------------------
    logic [NumCh-1:0] sync_q [SyncStages];
    logic [NumCh-1:0] sw_s;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_i;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sw_s = sync_q[SyncStages-1];

    // ------------------------------------------------------------------------
    // Shared millisecond prescaler, free-running from reset
    // ------------------------------------------------------------------------
    logic [PsW-1:0] ps_cnt;
    logic           ms_tick;

    assign ms_tick = (ps_cnt == PsMax);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps_cnt <= '0;
        end else if (ms_tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel filter and long-press detector
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        logic [CntW-1:0] cnt;
        logic [LpW-1:0]  lp;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;
        logic            long_q;

        // Any sample that agrees with the current level restarts the count,
        // so the level only flips after StableCycles consecutive differing
        // samples. The edge ticks are registered alongside the level so they
        // appear in the same cycle the new level becomes visible.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt     <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sw_s[c] == level_q) begin
                    cnt <= '0;
                end else if (cnt == CntMax) begin
                    cnt     <= '0;
                    level_q <= sw_s[c];
                    rise_q  <= sw_s[c];
                    fall_q  <= ~sw_s[c];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // lp saturates at LongPressMs, so long_q fires once per press.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                lp     <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    lp <= '0;
                end else if (ms_tick && (lp < LpMax)) begin
                    lp     <= lp + 1'b1;
                    long_q <= (lp == LpPre);
                end
            end
        end

        assign db_level_o[c] = level_q;
        assign rise_o[c]     = rise_q;
        assign fall_o[c]     = fall_q;
        assign long_o[c]     = long_q;
    end

    // ------------------------------------------------------------------------
    // Sticky event flags and interrupt; a new event wins over a clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            pend_o <= (pend_o & ~clr_i) | rise_o | fall_o | long_o;
            irq_o  <= |pend_o;
        end
    end

endmodule
